rv_int_unit: RTL and testbench

RV_INT_UNIT -- requirements
Module: rv_int_unit

---
 rtl/rv_int_unit.sv | 122 ++++++++++++
 tb/tb_rv_int_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_int_unit.sv
// Trap/interrupt redirect unit for a single-cycle RV32 core: selects the next PC and keeps mepc, mcause, mie, mpie.
// Optional macro RV_INT_VECTORED_EN sends interrupts to MTVEC + 32'h2C instead of MTVEC.
module rv_int_unit #(
  parameter logic [31:0] MTVEC    = 32'h0000_0008,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        ill_instr,
  input  logic        ecall,
  input  logic        mret,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic        mie,
  output logic        trap
);

`ifdef RV_INT_VECTORED_EN
  localparam logic [31:0] INT_TARGET = MTVEC + 32'h0000_002C;
`else
  localparam logic [31:0] INT_TARGET = MTVEC;
`endif

  localparam logic [31:0] CAUSE_ILL   = 32'd2;
  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam logic [31:0] CAUSE_INT   = 32'h8000_000B;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_ILL,
    ACT_ECALL,
    ACT_INT,
    ACT_MRET
  } action_e;

  action_e    action;
  logic [2:0] sync_q;
  logic       int_rise;
  logic       int_pend;
  logic       mpie;

  // sync_q[1] is the synchronized INT; sync_q[2] is its previous value for edge detection.
  assign int_rise = sync_q[1] & ~sync_q[2];

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    action = ACT_NONE;
    if (ill_instr)             action = ACT_ILL;
    else if (ecall)            action = ACT_ECALL;
    else if (int_pend && mie)  action = ACT_INT;
    else if (mret)             action = ACT_MRET;
  end

  always_comb begin
    pc   = pc_next;
    trap = 1'b0;
    if (rst) begin
      pc = RESET_PC;
    end else begin
      unique case (action)
        ACT_ILL, ACT_ECALL: begin pc = MTVEC;      trap = 1'b1; end
        ACT_INT:            begin pc = INT_TARGET; trap = 1'b1; end
        ACT_MRET:           pc = mepc;
        default:            pc = pc_next;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b000;
    else     sync_q <= {sync_q[1:0], INT};
  end

  // A new edge in the same cycle an interrupt is taken stays pending as a fresh request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   int_pend <= 1'b0;
    else if (int_rise)         int_pend <= 1'b1;
    else if (action == ACT_INT) int_pend <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc   <= 32'd0;
      mcause <= 32'd0;
      mie    <= 1'b1;
      mpie   <= 1'b0;
    end else begin
      unique case (action)
        ACT_ILL: begin
          mepc   <= pc_cur;
          mcause <= CAUSE_ILL;
          mpie   <= mie;
          mie    <= 1'b0;
        end
        ACT_ECALL: begin
          mepc   <= pc_cur;
          mcause <= CAUSE_ECALL;
          mpie   <= mie;
          mie    <= 1'b0;
        end
        // The interrupted instruction completes, so return to its successor.
        ACT_INT: begin
          mepc   <= pc_next;
          mcause <= CAUSE_INT;
          mpie   <= mie;
          mie    <= 1'b0;
        end
        ACT_MRET: begin
          mie  <= mpie;
          mpie <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_int_unit.sv
// Self-checking bench for rv_int_unit: directed scenarios plus a randomized run against a rule-level model.
module tb_rv_int_unit;

  localparam logic [31:0] MTVEC    = 32'h0000_0008;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RV_INT_VECTORED_EN
  localparam logic [31:0] INT_TGT  = 32'h0000_0034;
`else
  localparam logic [31:0] INT_TGT  = 32'h0000_0008;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        ill_instr = 1'b0;
  logic        ecall = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] pc_cur = 32'd0;
  logic [31:0] pc_next = 32'd4;
  logic [31:0] pc, mepc, mcause;
  logic        mie, trap;

  int n_checks = 0;
  int n_errs   = 0;

  rv_int_unit #(.MTVEC(MTVEC), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .INT(INT), .ill_instr(ill_instr), .ecall(ecall), .mret(mret),
    .pc_cur(pc_cur), .pc_next(pc_next), .pc(pc), .mepc(mepc), .mcause(mcause),
    .mie(mie), .trap(trap)
  );

  always #5 clk = ~clk;

  // Reference model: INT samples per edge; a 0->1 pair seen two and three edges back sets pending.
  bit          m_hist[$];
  bit          m_pend, m_mie, m_mpie;
  logic [31:0] m_mepc, m_mcause;
  logic [31:0] e_pc;
  logic        e_trap;
  bit          m_rise, m_exc, m_take;
  int          m_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist = {1'b0, 1'b0, 1'b0};
      m_pend = 0; m_mie = 1; m_mpie = 0; m_mepc = 0; m_mcause = 0;
    end else begin
      m_n    = m_hist.size();
      m_rise = m_hist[m_n-2] && !m_hist[m_n-3];
      m_hist.push_back(INT);
      m_exc  = ill_instr || ecall;
      m_take = m_pend && m_mie && !m_exc;
      if (m_exc) begin
        m_mepc = pc_cur; m_mcause = ill_instr ? 32'd2 : 32'd11;
        m_mpie = m_mie;  m_mie = 0;
      end else if (m_take) begin
        m_mepc = pc_next; m_mcause = 32'h8000_000B;
        m_mpie = m_mie;   m_mie = 0;
      end else if (mret) begin
        m_mie = m_mpie; m_mpie = 1;
      end
      if (m_rise)      m_pend = 1;
      else if (m_take) m_pend = 0;
    end
  end

  task automatic model_expect();
    e_trap = 0;
    if (rst)                            e_pc = RESET_PC;
    else if (ill_instr || ecall)      begin e_pc = MTVEC;   e_trap = 1; end
    else if (m_pend && m_mie)         begin e_pc = INT_TGT; e_trap = 1; end
    else if (mret)                      e_pc = m_mepc;
    else                                e_pc = pc_next;
  endtask

  task automatic apply(input logic i_ill, input logic i_ecall, input logic i_mret,
                       input logic [31:0] cur, input logic [31:0] nxt);
    ill_instr = i_ill; ecall = i_ecall; mret = i_mret; pc_cur = cur; pc_next = nxt;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 32'h0, 32'h4);
    INT = 0;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    apply(0, 0, 0, 32'h10, 32'h14);
    rst = 1; #2;
    n_checks++; if (pc !== RESET_PC) begin n_errs++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
    n_checks++; if (trap !== 1'b0) begin n_errs++; $display("FAIL reset_trap got=%b exp=0", trap); end
    @(posedge clk); #1;
    n_checks++; if (mepc !== 32'd0) begin n_errs++; $display("FAIL reset_mepc got=%h exp=0", mepc); end
    n_checks++; if (mcause !== 32'd0) begin n_errs++; $display("FAIL reset_mcause got=%h exp=0", mcause); end
    n_checks++; if (mie !== 1'b1) begin n_errs++; $display("FAIL reset_mie got=%b exp=1", mie); end
    rst = 0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h14) begin n_errs++; $display("FAIL post_reset_pc got=%h exp=00000014", pc); end
    next_cycle();
  endtask

  task automatic test_illegal();
    do_reset();
    apply(1, 0, 0, 32'h40, 32'h44);
    @(negedge clk);
    n_checks++; if (pc !== 32'h08) begin n_errs++; $display("FAIL ill_pc got=%h exp=00000008", pc); end
    n_checks++; if (trap !== 1'b1) begin n_errs++; $display("FAIL ill_trap got=%b exp=1", trap); end
    next_cycle();
    apply(0, 0, 0, 32'h08, 32'h0C);
    @(negedge clk);
    n_checks++; if (mepc !== 32'h40) begin n_errs++; $display("FAIL ill_mepc got=%h exp=00000040", mepc); end
    n_checks++; if (mcause !== 32'd2) begin n_errs++; $display("FAIL ill_mcause got=%h exp=2", mcause); end
    n_checks++; if (mie !== 1'b0) begin n_errs++; $display("FAIL ill_mie got=%b exp=0", mie); end
    n_checks++; if (trap !== 1'b0 || pc !== 32'h0C) begin n_errs++; $display("FAIL ill_after got trap=%b pc=%h exp trap=0 pc=0000000c", trap, pc); end
    next_cycle();
  endtask

  task automatic test_ecall_mret();
    do_reset();
    apply(0, 1, 0, 32'h100, 32'h104);
    @(negedge clk);
    n_checks++; if (pc !== MTVEC || trap !== 1'b1) begin n_errs++; $display("FAIL ecall_redirect got pc=%h trap=%b exp pc=%h trap=1", pc, trap, MTVEC); end
    next_cycle();
    apply(0, 0, 0, 32'h08, 32'h0C);
    next_cycle();
    apply(0, 0, 1, 32'h0C, 32'h10);
    @(negedge clk);
    n_checks++; if (mepc !== 32'h100) begin n_errs++; $display("FAIL ecall_mepc got=%h exp=00000100", mepc); end
    n_checks++; if (mcause !== 32'd11) begin n_errs++; $display("FAIL ecall_mcause got=%h exp=11", mcause); end
    n_checks++; if (pc !== 32'h100 || trap !== 1'b0) begin n_errs++; $display("FAIL mret_pc got pc=%h trap=%b exp pc=00000100 trap=0", pc, trap); end
    next_cycle();
    apply(0, 0, 0, 32'h100, 32'h104);
    @(negedge clk);
    n_checks++; if (mie !== 1'b1) begin n_errs++; $display("FAIL mret_mie got=%b exp=1", mie); end
    next_cycle();
  endtask

  task automatic test_interrupt();
    int first_trap;
    do_reset();
    INT = 1;
    first_trap = 0;
    for (int k = 1; k <= 4; k++) begin
      apply(0, 0, 0, 32'h20, 32'h24);
      @(negedge clk);
      if (trap === 1'b1 && first_trap == 0) begin
        first_trap = k;
        n_checks++; if (pc !== INT_TGT) begin n_errs++; $display("FAIL int_target got=%h exp=%h", pc, INT_TGT); end
      end
      next_cycle();
    end
    n_checks++; if (first_trap != 4) begin n_errs++; $display("FAIL int_latency got=%0d exp=4", first_trap); end
    apply(0, 0, 0, INT_TGT, INT_TGT + 4);
    @(negedge clk);
    n_checks++; if (mepc !== 32'h24) begin n_errs++; $display("FAIL int_mepc got=%h exp=00000024", mepc); end
    n_checks++; if (mcause !== 32'h8000_000B) begin n_errs++; $display("FAIL int_mcause got=%h exp=8000000b", mcause); end
    next_cycle();
    // INT stays high: after mret no second interrupt may appear.
    apply(0, 0, 1, INT_TGT + 4, INT_TGT + 8);
    @(negedge clk);
    n_checks++; if (pc !== 32'h24) begin n_errs++; $display("FAIL int_mret_pc got=%h exp=00000024", pc); end
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      apply(0, 0, 0, 32'h24 + 4*k, 32'h28 + 4*k);
      @(negedge clk);
      n_checks++; if (trap !== 1'b0) begin n_errs++; $display("FAIL int_held_retrigger cycle=%0d got=%b exp=0", k, trap); end
      next_cycle();
    end
    INT = 0;
  endtask

  task automatic pulse_int();
    INT = 1; next_cycle();
    INT = 0; next_cycle();
  endtask

  task automatic test_masked_interrupt();
    int seen;
    do_reset();
    apply(0, 1, 0, 32'h80, 32'h84);
    next_cycle();
    apply(0, 0, 0, 32'h08, 32'h0C);
    seen = 0;
    pulse_int();
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (trap === 1'b1) seen++; next_cycle(); end
    pulse_int();
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (trap === 1'b1) seen++; next_cycle(); end
    n_checks++; if (seen != 0) begin n_errs++; $display("FAIL masked_no_trap got=%0d exp=0", seen); end
    apply(0, 0, 1, 32'h10, 32'h14);
    @(negedge clk);
    n_checks++; if (trap !== 1'b0 || pc !== 32'h80) begin n_errs++; $display("FAIL masked_mret got trap=%b pc=%h exp trap=0 pc=00000080", trap, pc); end
    next_cycle();
    apply(0, 0, 0, 32'h80, 32'h84);
    @(negedge clk);
    n_checks++; if (trap !== 1'b1 || pc !== INT_TGT) begin n_errs++; $display("FAIL masked_take got trap=%b pc=%h exp trap=1 pc=%h", trap, pc, INT_TGT); end
    next_cycle();
    apply(0, 0, 0, INT_TGT, INT_TGT + 4);
    @(negedge clk);
    n_checks++; if (mepc !== 32'h84 || mcause !== 32'h8000_000B) begin n_errs++; $display("FAIL masked_csr got mepc=%h mcause=%h exp mepc=00000084 mcause=8000000b", mepc, mcause); end
    next_cycle();
    apply(0, 0, 1, INT_TGT + 4, INT_TGT + 8);
    next_cycle();
    seen = 0;
    apply(0, 0, 0, 32'h84, 32'h88);
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (trap === 1'b1) seen++; next_cycle(); end
    n_checks++; if (seen != 0) begin n_errs++; $display("FAIL absorbed_edge got=%0d exp=0", seen); end
  endtask

  task automatic test_ecall_blocks_int();
    do_reset();
    apply(0, 0, 0, 32'h1F0, 32'h1F4);
    INT = 1; next_cycle();
    INT = 0; next_cycle(); next_cycle();
    apply(0, 1, 0, 32'h200, 32'h204);
    @(negedge clk);
    n_checks++; if (trap !== 1'b1 || pc !== MTVEC) begin n_errs++; $display("FAIL blk_ecall got trap=%b pc=%h exp trap=1 pc=%h", trap, pc, MTVEC); end
    next_cycle();
    apply(0, 0, 0, 32'h08, 32'h0C);
    @(negedge clk);
    n_checks++; if (mcause !== 32'd11 || trap !== 1'b0) begin n_errs++; $display("FAIL blk_handler got mcause=%h trap=%b exp mcause=11 trap=0", mcause, trap); end
    next_cycle();
    apply(0, 0, 1, 32'h0C, 32'h10);
    @(negedge clk);
    n_checks++; if (pc !== 32'h200 || trap !== 1'b0) begin n_errs++; $display("FAIL blk_mret got pc=%h trap=%b exp pc=00000200 trap=0", pc, trap); end
    next_cycle();
    apply(0, 0, 0, 32'h200, 32'h204);
    @(negedge clk);
    n_checks++; if (trap !== 1'b1) begin n_errs++; $display("FAIL blk_pending_take got=%b exp=1", trap); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (mcause !== 32'h8000_000B || mepc !== 32'h204) begin n_errs++; $display("FAIL blk_int_csr got mcause=%h mepc=%h exp 8000000b/00000204", mcause, mepc); end
    next_cycle();
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    apply(1, 0, 0, 32'h300, 32'h304);
    @(negedge clk);
    #2 rst = 1;
    #1;
    n_checks++; if (pc !== RESET_PC || trap !== 1'b0) begin n_errs++; $display("FAIL midtrap_async got pc=%h trap=%b exp pc=%h trap=0", pc, trap, RESET_PC); end
    next_cycle();
    apply(0, 0, 0, 32'h0, 32'h4);
    rst = 0;
    @(negedge clk);
    n_checks++; if (mepc !== 32'd0 || mcause !== 32'd0 || mie !== 1'b1) begin n_errs++; $display("FAIL midtrap_csr got mepc=%h mcause=%h mie=%b exp 0/0/1", mepc, mcause, mie); end
    apply(0, 1, 0, 32'h50, 32'h54);
    next_cycle();
    apply(0, 0, 0, 32'h08, 32'h0C);
    @(negedge clk);
    n_checks++; if (mepc !== 32'h50 || mcause !== 32'd11) begin n_errs++; $display("FAIL first_edge got mepc=%h mcause=%h exp 00000050/11", mepc, mcause); end
    next_cycle();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      apply(r < 5, r >= 5 && r < 10, r >= 10 && r < 22,
            $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) == 0) INT = ~INT;
      @(negedge clk);
      model_expect();
      n_checks++; if (pc !== e_pc) begin n_errs++; $display("FAIL rnd_pc cycle=%0d got=%h exp=%h", k, pc, e_pc); end
      n_checks++; if (trap !== e_trap) begin n_errs++; $display("FAIL rnd_trap cycle=%0d got=%b exp=%b", k, trap, e_trap); end
      n_checks++; if (mepc !== m_mepc) begin n_errs++; $display("FAIL rnd_mepc cycle=%0d got=%h exp=%h", k, mepc, m_mepc); end
      n_checks++; if (mcause !== m_mcause) begin n_errs++; $display("FAIL rnd_mcause cycle=%0d got=%h exp=%h", k, mcause, m_mcause); end
      n_checks++; if (mie !== m_mie) begin n_errs++; $display("FAIL rnd_mie cycle=%0d got=%b exp=%b", k, mie, m_mie); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_ecall_mret();
    test_interrupt();
    test_masked_interrupt();
    test_ecall_blocks_int();
    test_reset_mid_trap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
